// File: rtl/modulation_sampler.sv
// rtl/modulation_sampler.sv - steps through the modulation BRAM at a programmable period and strobes samples to the modulator
// Optional sticky OVERRUN flag is built only when MOD_SAMPLER_OVERRUN_EN is defined.
module modulation_sampler #(
    parameter int ADDR_WIDTH = 12,
    parameter int DIV_WIDTH  = 16
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  EN,
    input  logic [DIV_WIDTH-1:0]  FREQ_DIV,
    input  logic [ADDR_WIDTH-1:0] CYCLE,
    input  logic                  READY,
    output logic [ADDR_WIDTH-1:0] BRAM_ADDR,
    input  logic [7:0]            BRAM_DATA,
    output logic [7:0]            MOD,
    output logic                  UPDATE,
    output logic                  OVERRUN
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    logic [0:0]            state;
    logic [DIV_WIDTH-1:0]  div_cnt;
    logic [DIV_WIDTH-1:0]  period;
    logic [ADDR_WIDTH-1:0] idx;
    logic [ADDR_WIDTH-1:0] fetch_addr;
    logic                  fetch_q1;
    logic                  fetch_q2;
    logic                  pending;
    logic [7:0]            pend_data;
    logic                  run_active;
    logic                  tick;
    logic                  capture;
    logic                  deliver;

    always_comb begin
        period     = (FREQ_DIV < DIV_WIDTH'(4)) ? DIV_WIDTH'(4) : FREQ_DIV;
        run_active = (state == ST_RUN) && EN;
        // ">=" so a FREQ_DIV lowered below the running count still ticks promptly
        tick       = run_active && (div_cnt >= period - 1'b1);
        // Guards the read itself when CYCLE shrinks below an already-advanced idx
        fetch_addr = (idx > CYCLE) ? '0 : idx;
        capture    = run_active && fetch_q2;
        deliver    = run_active && pending && READY;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= ST_IDLE;
            div_cnt   <= '0;
            idx       <= '0;
            BRAM_ADDR <= '0;
            fetch_q1  <= 1'b0;
            fetch_q2  <= 1'b0;
            pending   <= 1'b0;
            pend_data <= 8'h00;
            MOD       <= 8'h00;
            UPDATE    <= 1'b0;
        end else begin
            UPDATE <= 1'b0;
            if (!run_active) begin
                // Idle, or leaving RUN: drop everything in flight, keep MOD
                state    <= EN ? ST_RUN : ST_IDLE;
                div_cnt  <= '0;
                idx      <= '0;
                fetch_q1 <= 1'b0;
                fetch_q2 <= 1'b0;
                pending  <= 1'b0;
            end else begin
                div_cnt  <= tick ? '0 : div_cnt + 1'b1;
                fetch_q1 <= tick;
                fetch_q2 <= fetch_q1;
                if (tick) begin
                    BRAM_ADDR <= fetch_addr;
                    idx       <= (fetch_addr >= CYCLE) ? '0 : fetch_addr + 1'b1;
                end
                if (deliver) begin
                    MOD    <= pend_data;
                    UPDATE <= 1'b1;
                end
                if (capture) begin
                    pend_data <= BRAM_DATA;
                    pending   <= 1'b1;
                end else if (deliver) begin
                    pending <= 1'b0;
                end
            end
        end
    end

`ifdef MOD_SAMPLER_OVERRUN_EN
    always_ff @(posedge CLK) begin
        if (RST || !run_active) begin
            OVERRUN <= 1'b0;
        end else if (capture && pending && !READY) begin
            OVERRUN <= 1'b1;
        end
    end
`else
    assign OVERRUN = 1'b0;
`endif

endmodule

// File: tb/tb_modulation_sampler.sv
// tb/tb_modulation_sampler.sv - directed self-checking bench for modulation_sampler
module tb_modulation_sampler;

    logic        CLK = 1'b0;
    logic        RST;
    logic        EN;
    logic [15:0] FREQ_DIV;
    logic [11:0] CYCLE;
    logic        READY;
    logic [11:0] BRAM_ADDR;
    logic [7:0]  BRAM_DATA = 8'h00;
    logic [7:0]  MOD;
    logic        UPDATE;
    logic        OVERRUN;

    logic [7:0]  mem [0:15];
    int          n_checks = 0;
    int          n_fails  = 0;
    logic        seen;

`ifdef MOD_SAMPLER_OVERRUN_EN
    localparam logic EXP_OVR = 1'b1;
`else
    localparam logic EXP_OVR = 1'b0;
`endif

    modulation_sampler #(.ADDR_WIDTH(12), .DIV_WIDTH(16)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .EN        (EN),
        .FREQ_DIV  (FREQ_DIV),
        .CYCLE     (CYCLE),
        .READY     (READY),
        .BRAM_ADDR (BRAM_ADDR),
        .BRAM_DATA (BRAM_DATA),
        .MOD       (MOD),
        .UPDATE    (UPDATE),
        .OVERRUN   (OVERRUN)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) BRAM_DATA <= mem[BRAM_ADDR[3:0]];

    task automatic step(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 8'((i + 1) * 16);
        RST = 1'b1; EN = 1'b0; FREQ_DIV = 16'd10; CYCLE = 12'd2; READY = 1'b1;
        step(2);
        RST = 1'b0;
        chk("reset_mod", 32'(MOD), 32'h00);
        chk("reset_update", 32'(UPDATE), 32'd0);
        chk("reset_addr", 32'(BRAM_ADDR), 32'd0);
        chk("reset_overrun", 32'(OVERRUN), 32'd0);

        // Period 10, three-sample buffer
        EN = 1'b1;
        step(1);
        step(12);
        chk("first_update_early", 32'(UPDATE), 32'd0);
        step(1);
        chk("first_update", 32'(UPDATE), 32'd1);
        chk("first_mod", 32'(MOD), 32'h10);
        step(1);
        chk("strobe_one_cycle", 32'(UPDATE), 32'd0);
        step(9);
        chk("second_update", 32'(UPDATE), 32'd1);
        chk("second_mod", 32'(MOD), 32'h20);
        step(10);
        chk("third_mod", 32'(MOD), 32'h30);
        step(10);
        chk("wrap_update", 32'(UPDATE), 32'd1);
        chk("wrap_mod", 32'(MOD), 32'h10);

        // FREQ_DIV below the minimum runs at period 4
        EN = 1'b0;
        step(2);
        FREQ_DIV = 16'd1; EN = 1'b1;
        step(1);
        step(7);
        chk("div1_update_a", 32'(UPDATE), 32'd1);
        chk("div1_mod_a", 32'(MOD), 32'h10);
        step(3);
        chk("div1_gap", 32'(UPDATE), 32'd0);
        step(1);
        chk("div1_update_b", 32'(UPDATE), 32'd1);
        chk("div1_mod_b", 32'(MOD), 32'h20);

        // Short READY stall holds the sample in pending
        EN = 1'b0;
        step(2);
        FREQ_DIV = 16'd20; EN = 1'b1;
        step(1);
        step(20);
        READY = 1'b0;
        step(8);
        chk("stall_no_update", 32'(UPDATE), 32'd0);
        chk("stall_mod_held", 32'(MOD), 32'h20);
        READY = 1'b1;
        step(1);
        chk("stall_release_update", 32'(UPDATE), 32'd1);
        chk("stall_release_mod", 32'(MOD), 32'h10);
        chk("stall_no_overrun", 32'(OVERRUN), 32'd0);

        // Long stall: newest sample wins
        EN = 1'b0;
        step(2);
        EN = 1'b1;
        step(1);
        READY = 1'b0;
        step(45);
        chk("long_stall_no_update", 32'(UPDATE), 32'd0);
        chk("long_stall_mod_held", 32'(MOD), 32'h10);
        chk("long_stall_overrun", 32'(OVERRUN), 32'(EXP_OVR));
        READY = 1'b1;
        step(1);
        chk("long_stall_update", 32'(UPDATE), 32'd1);
        chk("long_stall_newest", 32'(MOD), 32'h20);
        EN = 1'b0;
        step(1);
        chk("overrun_cleared_idle", 32'(OVERRUN), 32'd0);
        step(1);

        // CYCLE shrinks below the running index
        FREQ_DIV = 16'd4; CYCLE = 12'd7; EN = 1'b1;
        step(1);
        step(20);
        chk("shrink_addr_before", 32'(BRAM_ADDR), 32'd4);
        CYCLE = 12'd2;
        step(3);
        chk("shrink_mod_before", 32'(MOD), 32'h50);
        step(1);
        chk("shrink_addr_wrapped", 32'(BRAM_ADDR), 32'd0);
        step(3);
        chk("shrink_mod_wrapped", 32'(MOD), 32'h10);
        step(1);
        chk("shrink_addr_next", 32'(BRAM_ADDR), 32'd1);

        // EN dropped one cycle after a tick discards the fetch
        step(4);
        chk("abort_tick_addr", 32'(BRAM_ADDR), 32'd2);
        EN = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step(1);
            if (UPDATE) seen = 1'b1;
        end
        chk("abort_no_update", 32'(seen), 32'd0);
        chk("abort_mod_held", 32'(MOD), 32'h20);
        chk("abort_overrun", 32'(OVERRUN), 32'd0);
        EN = 1'b1;
        step(1);
        step(4);
        chk("restart_addr", 32'(BRAM_ADDR), 32'd0);
        step(3);
        chk("restart_update", 32'(UPDATE), 32'd1);
        chk("restart_mod", 32'(MOD), 32'h10);

        // Reset mid-fetch
        step(1);
        chk("rst_fetch_addr", 32'(BRAM_ADDR), 32'd1);
        RST = 1'b1;
        step(1);
        chk("rst_mid_mod", 32'(MOD), 32'h00);
        chk("rst_mid_update", 32'(UPDATE), 32'd0);
        chk("rst_mid_addr", 32'(BRAM_ADDR), 32'd0);
        chk("rst_mid_overrun", 32'(OVERRUN), 32'd0);
        RST = 1'b0;
        step(2);
        chk("rst_fetch_dropped", 32'(UPDATE), 32'd0);
        chk("rst_fetch_mod", 32'(MOD), 32'h00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
